// File: rtl/boot_reset_sequencer.sv
// Boot reset sequencer: waits for clock-generator lock, holds the SoC in
// reset for a fixed stretch, then enables instruction fetch after a delay.
//
// Parameters:
//   RST_HOLD_CYCLES    cycles soc_reset_n stays low once lock is qualified
//   FETCH_DELAY_CYCLES cycles from reset release to fetch enable
//   LOCK_STABLE_CYCLES consecutive locked cycles needed by the lock filter
// Ports:
//   core_clk        clock from the clock generator
//   reset           asynchronous active-high reset
//   mmcm_locked     lock status, asynchronous to core_clk
//   soc_reset_n     active-low SoC core reset
//   fetch_enable_o  SoC fetch enable (RUN only)
//   seq_state_o     state: 0 WAIT_LOCK, 1 STRETCH, 2 DELAY, 3 RUN
//   lock_loss_cnt_o saturating count of lock-loss events
// Build option: define BOOT_LOCK_FILTER_EN to require a stable lock
// for LOCK_STABLE_CYCLES cycles before leaving WAIT_LOCK.
module boot_reset_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES    = 16,
  parameter int unsigned FETCH_DELAY_CYCLES = 8,
  parameter int unsigned LOCK_STABLE_CYCLES = 64
) (
  input  logic       core_clk,
  input  logic       reset,
  input  logic       mmcm_locked,
  output logic       soc_reset_n,
  output logic       fetch_enable_o,
  output logic [1:0] seq_state_o,
  output logic [7:0] lock_loss_cnt_o
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STRETCH   = 2'd1,
    DELAY     = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [15:0] HOLD_LAST  = 16'(RST_HOLD_CYCLES - 1);
  localparam logic [15:0] DELAY_LAST = 16'(FETCH_DELAY_CYCLES - 1);

  if (RST_HOLD_CYCLES < 1 || RST_HOLD_CYCLES > 65535) begin : g_bad_hold
    $error("RST_HOLD_CYCLES out of range 1..65535");
  end
  if (FETCH_DELAY_CYCLES < 1 || FETCH_DELAY_CYCLES > 65535) begin : g_bad_dly
    $error("FETCH_DELAY_CYCLES out of range 1..65535");
  end
  if (LOCK_STABLE_CYCLES < 1 || LOCK_STABLE_CYCLES > 65535) begin : g_bad_stb
    $error("LOCK_STABLE_CYCLES out of range 1..65535");
  end

  logic [1:0]  sync_q;
  logic        locked_s;
  logic        lock_qual;
  state_t      state;
  logic [15:0] cnt;

  // Two-flop synchronizer; nothing downstream looks at mmcm_locked.
  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], mmcm_locked};
    end
  end

  assign locked_s = sync_q[1];

`ifdef BOOT_LOCK_FILTER_EN
  localparam logic [15:0] FILT_MAX = 16'(LOCK_STABLE_CYCLES);

  logic [15:0] filt_cnt;

  // Counts consecutive locked cycles, saturating at FILT_MAX; any
  // unlocked cycle starts the qualification over.
  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      filt_cnt <= 16'd0;
    end else if (!locked_s) begin
      filt_cnt <= 16'd0;
    end else if (filt_cnt != FILT_MAX) begin
      filt_cnt <= filt_cnt + 16'd1;
    end
  end

  // locked_s is ANDed in so a drop is honoured before the count clears.
  assign lock_qual = locked_s && (filt_cnt == FILT_MAX);
`else
  assign lock_qual = locked_s;
`endif

  // Outputs are registered alongside the state so they carry no
  // combinational path from any input.
  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      state           <= WAIT_LOCK;
      cnt             <= 16'd0;
      soc_reset_n     <= 1'b0;
      fetch_enable_o  <= 1'b0;
      lock_loss_cnt_o <= 8'd0;
    end else if (state != WAIT_LOCK && !locked_s) begin
      // Lock loss outranks any counter expiry in the same cycle.
      state          <= WAIT_LOCK;
      cnt            <= 16'd0;
      soc_reset_n    <= 1'b0;
      fetch_enable_o <= 1'b0;
      if (lock_loss_cnt_o != 8'hFF) begin
        lock_loss_cnt_o <= lock_loss_cnt_o + 8'd1;
      end
    end else begin
      unique case (state)
        WAIT_LOCK: begin
          if (lock_qual) begin
            state <= STRETCH;
            cnt   <= 16'd0;
          end
        end
        STRETCH: begin
          if (cnt == HOLD_LAST) begin
            state       <= DELAY;
            cnt         <= 16'd0;
            soc_reset_n <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DELAY: begin
          if (cnt == DELAY_LAST) begin
            state          <= RUN;
            cnt            <= 16'd0;
            fetch_enable_o <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RUN: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign seq_state_o = state;

endmodule

// File: tb/tb_boot_reset_sequencer.sv
// Directed bench for boot_reset_sequencer (default parameters).
// Timing expectations shift by 64 edges when BOOT_LOCK_FILTER_EN is set.
module tb_boot_reset_sequencer;

`ifdef BOOT_LOCK_FILTER_EN
  localparam int Q = 64;
`else
  localparam int Q = 0;
`endif

  logic       clk;
  logic       reset;
  logic       mmcm_locked;
  logic       soc_reset_n;
  logic       fetch_enable_o;
  logic [1:0] seq_state_o;
  logic [7:0] lock_loss_cnt_o;

  int nvec;
  int nmis;

  boot_reset_sequencer dut (
    .core_clk        (clk),
    .reset           (reset),
    .mmcm_locked     (mmcm_locked),
    .soc_reset_n     (soc_reset_n),
    .fetch_enable_o  (fetch_enable_o),
    .seq_state_o     (seq_state_o),
    .lock_loss_cnt_o (lock_loss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       lk;
    logic [1:0] st;
    logic       rn;
    logic       fe;
    logic [7:0] llc;
  } vec_t;

  vec_t tbl[17];

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [1:0] st,
                     input logic rn, input logic fe,
                     input logic [7:0] llc);
    logic [11:0] got;
    logic [11:0] exp;
    got = {seq_state_o, soc_reset_n, fetch_enable_o, lock_loss_cnt_o};
    exp = {st, rn, fe, llc};
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got st=%0d rn=%b fe=%b llc=%0d, want st=%0d rn=%b fe=%b llc=%0d",
               nm, got[11:10], got[9], got[8], got[7:0],
               st, rn, fe, llc);
    end
  endtask

  // Holds reset over two edges, releases just after an edge with lock
  // already high, so the next edge is edge 1.
  task automatic restart();
    reset       = 1'b1;
    mmcm_locked = 1'b0;
    step(2);
    reset       = 1'b0;
    mmcm_locked = 1'b1;
  endtask

  initial begin
    nvec        = 0;
    nmis        = 0;
    reset       = 1'b1;
    mmcm_locked = 1'b0;

    tbl[0]  = '{0,     1'b1, 2'd0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{2,     1'b1, 2'd0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1 + Q, 1'b1, 2'd1, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{15,    1'b1, 2'd1, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{1,     1'b1, 2'd2, 1'b1, 1'b0, 8'd0};
    tbl[5]  = '{7,     1'b1, 2'd2, 1'b1, 1'b0, 8'd0};
    tbl[6]  = '{1,     1'b1, 2'd3, 1'b1, 1'b1, 8'd0};
    tbl[7]  = '{5,     1'b1, 2'd3, 1'b1, 1'b1, 8'd0};
    tbl[8]  = '{1,     1'b0, 2'd3, 1'b1, 1'b1, 8'd0};
    tbl[9]  = '{1,     1'b1, 2'd3, 1'b1, 1'b1, 8'd0};
    tbl[10] = '{1,     1'b1, 2'd0, 1'b0, 1'b0, 8'd1};
    tbl[11] = '{1 + Q, 1'b1, 2'd1, 1'b0, 1'b0, 8'd1};
    tbl[12] = '{15,    1'b1, 2'd1, 1'b0, 1'b0, 8'd1};
    tbl[13] = '{1,     1'b1, 2'd2, 1'b1, 1'b0, 8'd1};
    tbl[14] = '{7,     1'b1, 2'd2, 1'b1, 1'b0, 8'd1};
    tbl[15] = '{1,     1'b1, 2'd3, 1'b1, 1'b1, 8'd1};
    tbl[16] = '{3,     1'b1, 2'd3, 1'b1, 1'b1, 8'd1};

    // Reset values while reset is held.
    step(1);
    chk("in_reset", 2'd0, 1'b0, 1'b0, 8'd0);

    // Power-up sequence, one-cycle lock drop in RUN, full repeat.
    restart();
    for (int i = 0; i < 17; i++) begin
      mmcm_locked = tbl[i].lk;
      step(tbl[i].n);
      chk($sformatf("tbl%0d", i), tbl[i].st, tbl[i].rn,
          tbl[i].fe, tbl[i].llc);
    end

    // Lock drop seen on the edge where the stretch count expires.
    restart();
    step(16 + Q);
    mmcm_locked = 1'b0;
    step(1);
    mmcm_locked = 1'b1;
    step(1);
    chk("expiry_pre", 2'd1, 1'b0, 1'b0, 8'd0);
    step(1);
    chk("expiry_loss", 2'd0, 1'b0, 1'b0, 8'd1);

    // Asynchronous reset in DELAY, then a clean restart.
    restart();
    step(22 + Q);
    chk("mid_delay", 2'd2, 1'b1, 1'b0, 8'd0);
    reset = 1'b1;
    #1;
    chk("async_rst", 2'd0, 1'b0, 1'b0, 8'd0);
    step(2);
    chk("rst_held", 2'd0, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;
    step(2);
    chk("rr_e2", 2'd0, 1'b0, 1'b0, 8'd0);
    step(1 + Q);
    chk("rr_stretch", 2'd1, 1'b0, 1'b0, 8'd0);
    step(16);
    chk("rr_release", 2'd2, 1'b1, 1'b0, 8'd0);
    step(8);
    chk("rr_fetch", 2'd3, 1'b1, 1'b1, 8'd0);

`ifdef BOOT_LOCK_FILTER_EN
    // Glitch during qualification restarts the filter window.
    restart();
    step(39);
    mmcm_locked = 1'b0;
    step(1);
    mmcm_locked = 1'b1;
    step(66);
    chk("glitch_wait", 2'd0, 1'b0, 1'b0, 8'd0);
    step(1);
    chk("glitch_stretch", 2'd1, 1'b0, 1'b0, 8'd0);
    step(16);
    chk("glitch_release", 2'd2, 1'b1, 1'b0, 8'd0);
    step(8);
    chk("glitch_fetch", 2'd3, 1'b1, 1'b1, 8'd0);
`endif

    // 300 lock losses from STRETCH; the counter must stop at 255.
    restart();
    step(3 + Q);
    for (int i = 0; i < 300; i++) begin
      mmcm_locked = 1'b0;
      step(1);
      mmcm_locked = 1'b1;
      step(2);
      if (i == 253) chk("sat_254", 2'd0, 1'b0, 1'b0, 8'd254);
      if (i == 254) chk("sat_255", 2'd0, 1'b0, 1'b0, 8'd255);
      step(1 + Q);
    end
    chk("sat_300", 2'd1, 1'b0, 1'b0, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
